// File: rtl/hv_ramp_ctrl.sv
// HV power-supply ramp controller: steps an MCP DAC toward a clamped target one
// serializer transaction at a time, with dwell, safe-off and acknowledge timeout.
module hv_ramp_ctrl #(
  parameter logic [11:0] STEP     = 12'd230,
  parameter logic [23:0] DWELL    = 24'd78000,
  parameter logic [23:0] SETTLE   = 24'd192,
  parameter logic [11:0] MAX_CODE = 12'd2300,
  parameter logic [15:0] ACK_TO   = 16'd4096
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        hven_cmd,
  input  logic        safe_cmd,
  input  logic [11:0] target_code,
  input  logic        dac_busy,
  output logic        dac_pulse,
  output logic [11:0] dac_set,
  output logic        hven,
  output logic        at_target,
  output logic        fault,
  output logic [2:0]  ramp_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_WRITE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DWELL    = 3'd4,
    ST_HOLD     = 3'd5,
    ST_OFF      = 3'd6
  } state_t;

  state_t      state, state_n;
  logic [11:0] cur, cur_n;
  logic [11:0] nxt, nxt_n;
  logic [23:0] cnt, cnt_n;
  logic [15:0] ack_cnt, ack_cnt_n;
  logic        busy_seen, busy_seen_n;
  logic        safe_req, safe_req_n;
  logic        off_req, off_req_n;
  logic        dac_pulse_n;
  logic [11:0] dac_set_n;
  logic        hven_n;
  logic        at_target_n;
  logic        fault_n;

  logic        active;
  logic        safe_hit;
  logic        off_hit;
  logic [11:0] clamped;
  logic [11:0] goal_now;
  logic [11:0] step_code;
  logic        ack_expired;
  logic        go_off;
  logic        do_write;
  logic [11:0] write_code;

  // Moves cur toward goal by at most STEP; comparing the distance first keeps
  // the add/subtract inside 12 bits.
  function automatic logic [11:0] step_toward(input logic [11:0] from,
                                              input logic [11:0] goal);
    logic [11:0] diff;
    logic [11:0] res;
    res = goal;
    if (goal > from) begin
      diff = goal - from;
      if (diff > STEP) res = from + STEP;
    end else if (goal < from) begin
      diff = from - goal;
      if (diff > STEP) res = from - STEP;
    end
    return res;
  endfunction

  assign clamped     = (target_code > MAX_CODE) ? MAX_CODE : target_code;
  assign active      = (state == ST_SETTLE) || (state == ST_WRITE) ||
                       (state == ST_WAIT_ACK) || (state == ST_DWELL) ||
                       (state == ST_HOLD);
  assign safe_hit    = active && (safe_req || safe_cmd);
  assign off_hit     = active && (off_req || !hven_cmd);
  assign goal_now    = off_hit ? 12'd0 : clamped;
  assign step_code   = step_toward(cur, goal_now);
  assign ack_expired = ({1'b0, ack_cnt} + 17'd1) >= {1'b0, ACK_TO};

  // NOTE: every output of this block is assigned a default before the case
  // statement, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    cur_n       = cur;
    nxt_n       = nxt;
    cnt_n       = cnt;
    ack_cnt_n   = ack_cnt;
    busy_seen_n = busy_seen;
    safe_req_n  = safe_req;
    off_req_n   = off_req;
    dac_pulse_n = 1'b0;
    dac_set_n   = dac_set;
    hven_n      = hven;
    fault_n     = fault;
    go_off      = 1'b0;
    do_write    = 1'b0;
    write_code  = 12'd0;

    // Abort requests are latched so a one-cycle pulse still completes the
    // shutdown after an in-flight transaction.
    if (active) begin
      safe_req_n = safe_hit;
      off_req_n  = off_hit;
    end

    case (state)
      ST_IDLE: begin
        cur_n      = 12'd0;
        dac_set_n  = 12'd0;
        hven_n     = 1'b0;
        safe_req_n = 1'b0;
        off_req_n  = 1'b0;
        if (hven_cmd && !safe_cmd) begin
          hven_n  = 1'b1;
          cnt_n   = SETTLE;
          state_n = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (safe_hit || off_hit) begin
          go_off = 1'b1;
        end else if (cnt <= 24'd1) begin
          cnt_n   = 24'd0;
          state_n = ST_WRITE;
        end else begin
          cnt_n = cnt - 24'd1;
        end
      end

      ST_WRITE: begin
        if (safe_hit) begin
          if (cur == 12'd0) go_off = 1'b1;
          else if (!dac_busy) do_write = 1'b1;
        end else if (off_hit && (cur == 12'd0)) begin
          go_off = 1'b1;
        end else if (cur == goal_now) begin
          state_n = ST_HOLD;
        end else if (!dac_busy) begin
          do_write   = 1'b1;
          write_code = step_code;
        end
      end

      ST_WAIT_ACK: begin
        if (busy_seen && !dac_busy) begin
          cur_n     = nxt;
          ack_cnt_n = 16'd0;
          if ((safe_hit || off_hit) && (nxt == 12'd0)) begin
            go_off = 1'b1;
          end else if (safe_hit) begin
            state_n = ST_WRITE;
          end else begin
            cnt_n   = DWELL;
            state_n = ST_DWELL;
          end
        end else if (ack_expired) begin
          ack_cnt_n = 16'd0;
          fault_n   = 1'b1;
          go_off    = 1'b1;
        end else begin
          ack_cnt_n = ack_cnt + 16'd1;
          if (dac_busy) busy_seen_n = 1'b1;
        end
      end

      ST_DWELL: begin
        if (safe_hit) begin
          cnt_n   = 24'd0;
          state_n = ST_WRITE;
        end else if (cnt <= 24'd1) begin
          cnt_n = 24'd0;
          if (off_hit && (cur == 12'd0)) go_off = 1'b1;
          else if (cur == goal_now) state_n = ST_HOLD;
          else state_n = ST_WRITE;
        end else begin
          cnt_n = cnt - 24'd1;
        end
      end

      ST_HOLD: begin
        if (safe_hit || off_hit || (cur != goal_now)) state_n = ST_WRITE;
      end

      ST_OFF: begin
        hven_n    = 1'b0;
        dac_set_n = 12'd0;
        if (!hven_cmd) begin
          fault_n = 1'b0;
          state_n = ST_IDLE;
        end
      end

      default: go_off = 1'b1;
    endcase

    if (do_write) begin
      dac_pulse_n = 1'b1;
      dac_set_n   = write_code;
      nxt_n       = write_code;
      ack_cnt_n   = 16'd0;
      busy_seen_n = 1'b0;
      state_n     = ST_WAIT_ACK;
    end

    if (go_off) begin
      hven_n    = 1'b0;
      dac_set_n = 12'd0;
      cnt_n     = 24'd0;
      state_n   = ST_OFF;
    end

    at_target_n = (state_n == ST_HOLD);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur       <= 12'd0;
      nxt       <= 12'd0;
      cnt       <= 24'd0;
      ack_cnt   <= 16'd0;
      busy_seen <= 1'b0;
      safe_req  <= 1'b0;
      off_req   <= 1'b0;
      dac_pulse <= 1'b0;
      dac_set   <= 12'd0;
      hven      <= 1'b0;
      at_target <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      nxt       <= nxt_n;
      cnt       <= cnt_n;
      ack_cnt   <= ack_cnt_n;
      busy_seen <= busy_seen_n;
      safe_req  <= safe_req_n;
      off_req   <= off_req_n;
      dac_pulse <= dac_pulse_n;
      dac_set   <= dac_set_n;
      hven      <= hven_n;
      at_target <= at_target_n;
      fault     <= fault_n;
    end
  end

  assign ramp_state = state;

endmodule

// File: tb/tb_hv_ramp_ctrl.sv
// Scoreboard bench for hv_ramp_ctrl: expected DAC codes are queued by the
// stimulus and popped by a monitor on every dac_pulse.
module tb_hv_ramp_ctrl;

  localparam logic [23:0] T_DWELL  = 24'd100;
  localparam logic [23:0] T_SETTLE = 24'd10;
  localparam logic [15:0] T_ACK_TO = 16'd300;
  localparam int          BUSY_LEN = 20;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd5;
  localparam logic [2:0] S_OFF    = 3'd6;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic        hven_cmd;
  logic        safe_cmd;
  logic [11:0] target_code;
  logic        dac_busy;
  logic        dac_pulse;
  logic [11:0] dac_set;
  logic        hven;
  logic        at_target;
  logic        fault;
  logic [2:0]  ramp_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [11:0] exp_q[$];
  int          last_pulse_cyc = -1;
  logic        chk_gap = 1'b0;
  logic        prev_pulse = 1'b0;

  int busy_cnt = 0;
  logic ser_dead = 1'b0;

  hv_ramp_ctrl #(
    .STEP(12'd230), .DWELL(T_DWELL), .SETTLE(T_SETTLE),
    .MAX_CODE(12'd2300), .ACK_TO(T_ACK_TO)
  ) dut (
    .clk50(clk50), .rst_n(rst_n), .hven_cmd(hven_cmd), .safe_cmd(safe_cmd),
    .target_code(target_code), .dac_busy(dac_busy), .dac_pulse(dac_pulse),
    .dac_set(dac_set), .hven(hven), .at_target(at_target), .fault(fault),
    .ramp_state(ramp_state)
  );

  always #10 clk50 = ~clk50;

  always @(posedge clk50) cyc <= cyc + 1;

  // Serializer model: a sampled pulse keeps busy high for BUSY_LEN cycles.
  always @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (dac_pulse && !ser_dead) busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign dac_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every strobe against the scoreboard.
  always @(negedge clk50) begin
    if (dac_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got code %0d expected no pulse (cycle %0d)",
                 dac_set, cyc);
      end else begin
        check("dac_code", 32'(dac_set), 32'(exp_q.pop_front()));
        check("pulse_back_to_back", 32'(prev_pulse), 32'd0);
        if (chk_gap && last_pulse_cyc >= 0)
          check("pulse_spacing_ge_100", 32'((cyc - last_pulse_cyc) >= 100), 32'd1);
      end
      last_pulse_cyc = cyc;
    end
    prev_pulse = dac_pulse;
  end

  task automatic push_codes(input int from_code, input int to_code, input int step);
    int c;
    c = from_code;
    forever begin
      exp_q.push_back(12'(c));
      if (c == to_code) break;
      c = c + step;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (ramp_state !== st && n < budget) begin
      @(negedge clk50);
      n++;
    end
    check(name, 32'(ramp_state), 32'(st));
  endtask

  task automatic wait_code(input logic [11:0] code, input int budget, input string name);
    int n;
    n = 0;
    while (!(dac_pulse === 1'b1 && dac_set === code) && n < budget) begin
      @(negedge clk50);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    int n;
    n = 0;
    while (dac_busy !== level && n < budget) begin
      @(negedge clk50);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    hven_cmd    = 1'b0;
    safe_cmd    = 1'b0;
    target_code = 12'd0;
    repeat (3) @(negedge clk50);
    check("rst_state", 32'(ramp_state), 32'(S_IDLE));
    check("rst_hven", 32'(hven), 32'd0);
    check("rst_outputs", {dac_pulse, at_target, fault, dac_set}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk50);

    // safe_cmd wins over hven_cmd in IDLE
    hven_cmd = 1'b1;
    safe_cmd = 1'b1;
    repeat (5) @(negedge clk50);
    check("safe_priority_idle", 32'(ramp_state), 32'(S_IDLE));
    hven_cmd = 1'b0;
    safe_cmd = 1'b0;
    @(negedge clk50);

    // Ramp up to 2070 in nine steps
    chk_gap = 1'b1;
    last_pulse_cyc = -1;
    target_code = 12'd2070;
    push_codes(230, 2070, 230);
    hven_cmd = 1'b1;
    @(negedge clk50);
    check("hven_on_settle", {29'd0, hven, ramp_state}, {29'd0, 1'b1, S_SETTLE});
    wait_state(S_HOLD, 3000, "hold_2070");
    check("at_target_2070", {at_target, dac_set}, {1'b1, 12'd2070});
    check("queue_empty_up", 32'(exp_q.size()), 32'd0);

    // Down to 1000
    target_code = 12'd1000;
    exp_q.push_back(12'd1840); exp_q.push_back(12'd1610); exp_q.push_back(12'd1380);
    exp_q.push_back(12'd1150); exp_q.push_back(12'd1000);
    @(negedge clk50);
    @(negedge clk50);
    check("at_target_cleared", 32'(at_target), 32'd0);
    wait_state(S_HOLD, 3000, "hold_1000");
    check("at_target_1000", {at_target, dac_set}, {1'b1, 12'd1000});

    // Clamp: 3000 requested, ramp stops at 2300
    target_code = 12'd3000;
    push_codes(1230, 2150, 230);
    exp_q.push_back(12'd2300);
    @(negedge clk50);
    wait_state(S_HOLD, 3000, "hold_clamp");
    check("at_target_2300", {at_target, dac_set}, {1'b1, 12'd2300});

    // Settle at 920, then drop hven_cmd
    target_code = 12'd920;
    push_codes(2070, 920, -230);
    @(negedge clk50);
    wait_state(S_HOLD, 3000, "hold_920");
    push_codes(690, 0, -230);
    hven_cmd = 1'b0;
    wait_state(S_OFF, 3000, "rampdown_off");
    check("rampdown_hven", {hven, dac_set}, 32'd0);
    check("queue_empty_down", 32'(exp_q.size()), 32'd0);
    wait_state(S_IDLE, 10, "rearm_idle");

    // Safe request during WAIT_ACK at 1380
    chk_gap = 1'b0;
    target_code = 12'd2070;
    push_codes(230, 1380, 230);
    exp_q.push_back(12'd0);
    hven_cmd = 1'b1;
    wait_code(12'd1380, 3000, "saw_1380");
    @(negedge clk50);
    @(negedge clk50);
    safe_cmd = 1'b1;
    @(negedge clk50);
    safe_cmd = 1'b0;
    wait_code(12'd0, 200, "saw_safe_zero");
    @(negedge clk50);
    wait_busy(1'b1, 50, "safe_busy_rise");
    wait_busy(1'b0, 50, "safe_busy_fall");
    @(negedge clk50);
    check("safe_off_hven", {29'd0, hven, ramp_state}, {29'd0, 1'b0, S_OFF});
    repeat (20) @(negedge clk50);
    check("off_needs_rearm", 32'(ramp_state), 32'(S_OFF));
    hven_cmd = 1'b0;
    wait_state(S_IDLE, 10, "rearm_after_safe");

    // Acknowledge timeout
    ser_dead = 1'b1;
    target_code = 12'd500;
    exp_q.push_back(12'd230);
    hven_cmd = 1'b1;
    wait_code(12'd230, 200, "saw_to_pulse");
    n = 0;
    while (fault !== 1'b1 && n < 1000) begin
      @(negedge clk50);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(T_ACK_TO));
    check("timeout_off", {28'd0, fault, hven, ramp_state}, {28'd0, 1'b1, 1'b0, S_OFF});
    check("timeout_dac_zero", 32'(dac_set), 32'd0);
    ser_dead = 1'b0;
    hven_cmd = 1'b0;
    @(negedge clk50);
    @(negedge clk50);
    check("fault_cleared", {29'd0, fault, ramp_state}, {29'd0, 1'b0, S_IDLE});

    // Reset mid-ramp
    target_code = 12'd2070;
    exp_q.push_back(12'd230);
    exp_q.push_back(12'd460);
    hven_cmd = 1'b1;
    wait_code(12'd460, 1000, "saw_460");
    repeat (50) @(negedge clk50);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_hven", 32'(hven), 32'd0);
    check("midreset_outputs",
          {13'd0, dac_pulse, at_target, fault, ramp_state, dac_set},
          32'd0);
    hven_cmd = 1'b0;
    @(negedge clk50);
    rst_n = 1'b1;
    repeat (300) @(negedge clk50);
    check("post_reset_idle", 32'(ramp_state), 32'(S_IDLE));
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hv_ramp_ctrl.md
HV_RAMP_CTRL -- requirements
Module: hv_ramp_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 12'd230: maximum DAC code change per write.
REQ-002 SHALL have parameter DWELL, default 24'd78000: clk50 cycles to hold each step before the next write.
REQ-003 SHALL have parameter SETTLE, default 24'd192: clk50 cycles between hven assertion and the first write.
REQ-004 SHALL have parameter MAX_CODE, default 12'd2300: upper clamp on target_code.
REQ-005 SHALL have parameter ACK_TO, default 16'd4096: clk50 cycles allowed for a DAC transaction to complete.
REQ-006 SHALL have port clk50, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port hven_cmd, input, 1: request HV on.
REQ-009 SHALL have port safe_cmd, input, 1: emergency safe request.
REQ-010 SHALL have port target_code, input, 12: requested MCP DAC code.
REQ-011 SHALL have port dac_busy, input, 1: MCP DAC serializer transaction in progress.
REQ-012 SHALL have port dac_pulse, output, 1: one-cycle write strobe to the serializer.
REQ-013 SHALL have port dac_set, output, 12: code presented with dac_pulse.
REQ-014 SHALL have port hven, output, 1: HVPS enable.
REQ-015 SHALL have port at_target, output, 1: dac_set equals the clamped target in HOLD.
REQ-016 SHALL have port fault, output, 1: sticky DAC acknowledge timeout.
REQ-017 SHALL have port ramp_state, output, 3: current state encoding, for housekeeping.

Function
REQ-018 SHALL implement the states IDLE=0, SETTLE=1, WRITE=2, WAIT_ACK=3, DWELL=4, HOLD=5, OFF=6.
REQ-019 IDLE: hven=0 and dac_set=0; on hven_cmd & ~safe_cmd SHALL set hven=1, load the settle counter and go to SETTLE.
REQ-020 SETTLE: after SETTLE cycles SHALL go to WRITE with the goal equal to the clamped target.
REQ-021 The clamped target SHALL be min(target_code, MAX_CODE).
REQ-022 WRITE: when dac_busy=0, SHALL pulse dac_pulse for exactly 1 cycle with dac_set=next and go to WAIT_ACK; while dac_busy=1 it SHALL wait with no pulse.
REQ-023 next SHALL step toward the goal by at most STEP, using 12-bit unsigned arithmetic with no overflow or underflow:
  - if goal > cur, next = min(cur+STEP, goal);
  - if goal < cur, next = max(cur-STEP, goal).
REQ-024 WAIT_ACK: SHALL require dac_busy to rise and then fall; on the fall it SHALL set cur=next and go to DWELL.
REQ-025 WAIT_ACK timeout: after ACK_TO cycles without completion SHALL set fault=1, hven=0 and dac_set=0, and go to OFF.
REQ-026 DWELL: after DWELL cycles SHALL go to HOLD if cur==goal, otherwise to WRITE.
REQ-027 HOLD: at_target=1; a change of the clamped target SHALL set at_target=0 and start a new ramp (WRITE) toward the new value, up or down.
REQ-028 hven_cmd=0 in any active state SHALL force goal=0; the block SHALL ramp down in STEP decrements, then drop hven and go to OFF.
REQ-029 safe_cmd=1 in any active state SHALL force a single write of dac_set=0 (no stepping), then hven=0 and go to OFF.
REQ-030 safe_cmd has priority over hven_cmd when both are applied in the same cycle.
REQ-031 Abort or goal change during WAIT_ACK SHALL take effect only after the current transaction completes or times out; no dac_pulse while dac_busy=1.
REQ-032 safe_cmd during SETTLE, or with cur=0, SHALL skip the write and go directly to OFF.
REQ-033 OFF: hven=0; SHALL return to IDLE only after hven_cmd=0 is observed (re-arm required); fault SHALL clear on that transition.
REQ-034 dac_pulse SHALL never be asserted in two consecutive cycles.

Reset
REQ-035 On rst_n=0, asynchronously: state=IDLE, dac_pulse=0, dac_set=0, cur=0, hven=0, at_target=0, fault=0, all counters 0.
REQ-036 Reset mid-ramp SHALL drop hven immediately and issue no DAC write on release.

Verification
REQ-037 Bench with DWELL=100, SETTLE=10, serializer model 20 cycles busy; target=2070, hven_cmd=1 -> 9 pulses with codes 230, 460, 690, ..., 2070 each ≥100 cycles apart; at_target=1.
REQ-038 target=3000 -> ramp ends at 2300 (clamp), at_target=1.
REQ-039 In HOLD at 2070, set target=1000 -> writes 1840, 1610, 1380, 1150, 1000.
REQ-040 At cur=920 with hven_cmd dropped -> writes 690, 460, 230, 0, then hven=0 and OFF; re-arm only after hven_cmd low.
REQ-041 safe_cmd asserted during WAIT_ACK at 1380 -> transaction completes, one write of 0, hven=0 within one cycle of that acknowledge.
REQ-042 dac_busy held 0 after a pulse -> fault=1 at ACK_TO cycles, hven=0, OFF; rst_n pulse mid-ramp -> all outputs 0.
